batch_index_sequencer: RTL and testbench

//  Sequences a SIZE-bit request bitmap ("batch") into a stream of bit indices, lowest set bit first,
//  one index per accepted output handshake. Holds the batch in a register, clears each bit as it is

---
 rtl/batch_seq_pkg.sv | 24 ++
 rtl/batch_index_sequencer_scan.sv | 22 ++
 rtl/batch_index_sequencer.sv | 108 ++++++++++
 tb/tb_batch_index_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/batch_seq_pkg.sv
// Shared types and helpers for the batch index sequencer.
package batch_seq_pkg;

   localparam int SIZE_DEFAULT  = 64;
   localparam int CNT_W_DEFAULT = 16;
   // Widest bitmap the popcount helper handles; callers zero-extend into it.
   localparam int POP_MAX       = 1024;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_SCAN  = 1'b1
   } state_t;

   // Number of set bits in a zero-extended bitmap.
   function automatic int unsigned popcount(input logic [POP_MAX-1:0] vec);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX; i++) begin
         n = n + 32'(vec[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/batch_index_sequencer_scan.sv
// Lowest-set-bit finder: index of the least significant 1 and an any-set flag.
module bit_scan_lsb
   import batch_seq_pkg::*;
#(
   parameter int SIZE     = SIZE_DEFAULT,
   parameter int LOG_SIZE = $clog2(SIZE)
) (
   input  logic [SIZE-1:0]     vec,
   output logic [LOG_SIZE-1:0] idx,
   output logic                any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = |vec;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (vec[i]) idx = LOG_SIZE'(i);
      end
   end

endmodule

// File: rtl/batch_index_sequencer.sv
// Turns a request bitmap into a stream of set-bit indices, lowest first,
// and asks upstream for the next bitmap once the held one is exhausted.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | bitmap_q == 0, waiting for a batch (batch_ready = 1)
//   ST_SCAN  | bitmap_q != 0, presenting the lowest set bit on idx
module batch_index_sequencer
   import batch_seq_pkg::*;
#(
   parameter int SIZE     = SIZE_DEFAULT,
   parameter int LOG_SIZE = $clog2(SIZE),
   parameter int CNT_W    = CNT_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                batch_valid,
   output logic                batch_ready,
   input  logic [SIZE-1:0]     batch_data,
   output logic                batch_req,
   output logic                idx_valid,
   input  logic                idx_ready,
   output logic [LOG_SIZE-1:0] idx,
   output logic                idx_last,
   output logic [LOG_SIZE:0]   remaining,
   output logic                empty_batch,
   output logic [CNT_W-1:0]    batches_done
);

   state_t           state_q;
   logic [SIZE-1:0]  bitmap_q;
   logic             batch_req_q;
   logic             empty_batch_q;
   logic [CNT_W-1:0] batches_done_q;
   // Set by reset so the first cycle after release issues a batch request.
   logic             init_q;

   logic             any_set;
   logic [POP_MAX-1:0] bitmap_pad;
   logic             pop;
   logic             accept;
   logic [SIZE-1:0]  bitmap_cleared;

   bit_scan_lsb #(.SIZE(SIZE), .LOG_SIZE(LOG_SIZE)) u_scan (
      .vec (bitmap_q),
      .idx (idx),
      .any (any_set)
   );

   // Outputs derived from registers only; idx_ready reaches batch_ready to allow back-to-back batches.
   always_comb begin
      bitmap_pad             = '0;
      bitmap_pad[SIZE-1:0]   = bitmap_q;
      remaining              = (LOG_SIZE + 1)'(popcount(bitmap_pad));
      idx_last               = (remaining == (LOG_SIZE + 1)'(1));
      idx_valid              = (state_q == ST_SCAN);
      pop                    = idx_valid & idx_ready & any_set & ~flush;
      batch_ready            = ~flush & ((state_q == ST_EMPTY) |
                                         ((state_q == ST_SCAN) & idx_ready & idx_last));
      accept                 = batch_valid & batch_ready;
      bitmap_cleared         = bitmap_q & ~(SIZE'(1) << idx);
      batch_req              = batch_req_q;
      empty_batch            = empty_batch_q;
      batches_done           = batches_done_q;
   end

   // Sequencer FSM: load, pop, flush and completion counting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_EMPTY;
         bitmap_q       <= '0;
         batch_req_q    <= 1'b0;
         empty_batch_q  <= 1'b0;
         batches_done_q <= '0;
         init_q         <= 1'b1;
      end else begin
         batch_req_q   <= 1'b0;
         empty_batch_q <= 1'b0;
         init_q        <= 1'b0;
         if (flush) begin
            state_q     <= ST_EMPTY;
            bitmap_q    <= '0;
            batch_req_q <= 1'b1;
         end else begin
            if (init_q) batch_req_q <= 1'b1;
            if (pop && idx_last) batches_done_q <= batches_done_q + CNT_W'(1);
            if (accept) begin
               bitmap_q <= batch_data;
               if (batch_data == '0) begin
                  state_q       <= ST_EMPTY;
                  empty_batch_q <= 1'b1;
                  batch_req_q   <= 1'b1;
               end else begin
                  state_q <= ST_SCAN;
               end
            end else if (pop) begin
               bitmap_q <= bitmap_cleared;
               if (idx_last) begin
                  state_q     <= ST_EMPTY;
                  batch_req_q <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_batch_index_sequencer.sv
// Directed bench for batch_index_sequencer with hand-computed expectations.
module tb_batch_index_sequencer;

   localparam int SIZE     = 64;
   localparam int LOG_SIZE = 6;
   localparam int CNT_W    = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                flush;
   logic                batch_valid;
   logic                batch_ready;
   logic [SIZE-1:0]     batch_data;
   logic                batch_req;
   logic                idx_valid;
   logic                idx_ready;
   logic [LOG_SIZE-1:0] idx;
   logic                idx_last;
   logic [LOG_SIZE:0]   remaining;
   logic                empty_batch;
   logic [CNT_W-1:0]    batches_done;

   int n_vec = 0;
   int n_err = 0;

   batch_index_sequencer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .batch_valid  (batch_valid),
      .batch_ready  (batch_ready),
      .batch_data   (batch_data),
      .batch_req    (batch_req),
      .idx_valid    (idx_valid),
      .idx_ready    (idx_ready),
      .idx          (idx),
      .idx_last     (idx_last),
      .remaining    (remaining),
      .empty_batch  (empty_batch),
      .batches_done (batches_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      flush       = 1'b0;
      batch_valid = 1'b0;
      batch_data  = '0;
      idx_ready   = 1'b0;
      tick();
      tick();
      chk("rst batch_req",    64'(batch_req),    64'd0);
      chk("rst idx_valid",    64'(idx_valid),    64'd0);
      chk("rst batch_ready",  64'(batch_ready),  64'd1);
      chk("rst remaining",    64'(remaining),    64'd0);
      chk("rst idx",          64'(idx),          64'd0);
      chk("rst idx_last",     64'(idx_last),     64'd0);
      chk("rst empty_batch",  64'(empty_batch),  64'd0);
      chk("rst batches_done", 64'(batches_done), 64'd0);

      // 1: reset release
      rst_n = 1'b1;
      tick();
      chk("t1 batch_req",   64'(batch_req),   64'd1);
      chk("t1 batch_ready", 64'(batch_ready), 64'd1);
      chk("t1 idx_valid",   64'(idx_valid),   64'd0);
      chk("t1 remaining",   64'(remaining),   64'd0);
      tick();
      chk("t1 req once",    64'(batch_req),   64'd0);

      // 2: three-index batch
      batch_valid = 1'b1;
      batch_data  = 64'h8000_0000_0000_0005;
      idx_ready   = 1'b1;
      tick();
      batch_valid = 1'b0;
      chk("t2 valid0", 64'(idx_valid), 64'd1);
      chk("t2 idx0",   64'(idx),       64'd0);
      chk("t2 rem0",   64'(remaining), 64'd3);
      chk("t2 last0",  64'(idx_last),  64'd0);
      tick();
      chk("t2 idx1",   64'(idx),       64'd2);
      chk("t2 rem1",   64'(remaining), 64'd2);
      chk("t2 last1",  64'(idx_last),  64'd0);
      tick();
      chk("t2 idx2",   64'(idx),       64'd63);
      chk("t2 rem2",   64'(remaining), 64'd1);
      chk("t2 last2",  64'(idx_last),  64'd1);
      tick();
      chk("t2 valid end", 64'(idx_valid),    64'd0);
      chk("t2 done",      64'(batches_done), 64'd1);
      chk("t2 req",       64'(batch_req),    64'd1);
      tick();
      chk("t2 req drop",  64'(batch_req),    64'd0);

      // 3: back-to-back with stall
      idx_ready   = 1'b0;
      batch_valid = 1'b1;
      batch_data  = 64'h1;
      tick();
      batch_data  = 64'h3;
      chk("t3 idx a",      64'(idx),         64'd0);
      chk("t3 last a",     64'(idx_last),    64'd1);
      chk("t3 ready stall",64'(batch_ready), 64'd0);
      tick();
      chk("t3 hold idx",   64'(idx),         64'd0);
      chk("t3 hold rem",   64'(remaining),   64'd1);
      chk("t3 hold valid", 64'(idx_valid),   64'd1);
      idx_ready = 1'b1;
      #1;
      chk("t3 ready b2b",  64'(batch_ready), 64'd1);
      tick();
      batch_valid = 1'b0;
      chk("t3 valid b",    64'(idx_valid),    64'd1);
      chk("t3 idx b",      64'(idx),          64'd0);
      chk("t3 rem b",      64'(remaining),    64'd2);
      chk("t3 last b",     64'(idx_last),     64'd0);
      chk("t3 done b",     64'(batches_done), 64'd2);
      chk("t3 no req",     64'(batch_req),    64'd0);
      idx_ready = 1'b0;
      tick();
      chk("t3 stall idx",  64'(idx),          64'd0);
      chk("t3 stall rem",  64'(remaining),    64'd2);
      idx_ready = 1'b1;
      tick();
      chk("t3 idx c",      64'(idx),          64'd1);
      chk("t3 last c",     64'(idx_last),     64'd1);
      tick();
      chk("t3 valid end",  64'(idx_valid),    64'd0);
      chk("t3 done c",     64'(batches_done), 64'd3);
      chk("t3 req",        64'(batch_req),    64'd1);

      // 4: zero batch
      idx_ready   = 1'b0;
      batch_valid = 1'b1;
      batch_data  = '0;
      tick();
      batch_valid = 1'b0;
      chk("t4 empty_batch", 64'(empty_batch),  64'd1);
      chk("t4 req",         64'(batch_req),    64'd1);
      chk("t4 idx_valid",   64'(idx_valid),    64'd0);
      chk("t4 done",        64'(batches_done), 64'd3);
      tick();
      chk("t4 empty drop",  64'(empty_batch),  64'd0);
      chk("t4 req drop",    64'(batch_req),    64'd0);
      chk("t4 idle",        64'(idx_valid),    64'd0);

      // 5: flush
      idx_ready   = 1'b1;
      batch_valid = 1'b1;
      batch_data  = 64'hF0;
      tick();
      batch_valid = 1'b0;
      chk("t5 idx4", 64'(idx),       64'd4);
      chk("t5 rem4", 64'(remaining), 64'd4);
      tick();
      chk("t5 idx5", 64'(idx),       64'd5);
      chk("t5 rem3", 64'(remaining), 64'd3);
      flush       = 1'b1;
      batch_valid = 1'b1;
      batch_data  = 64'hFF;
      #1;
      chk("t5 ready flush", 64'(batch_ready), 64'd0);
      tick();
      flush       = 1'b0;
      batch_valid = 1'b0;
      chk("t5 valid",  64'(idx_valid),    64'd0);
      chk("t5 rem",    64'(remaining),    64'd0);
      chk("t5 req",    64'(batch_req),    64'd1);
      chk("t5 done",   64'(batches_done), 64'd3);
      tick();
      chk("t5 not accepted", 64'(idx_valid), 64'd0);
      chk("t5 req drop",     64'(batch_req), 64'd0);

      // 6: counter preset to 65535 via single-bit batches, then all-ones wraps it
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      batch_valid = 1'b1;
      idx_ready   = 1'b1;
      for (int n = 0; n < 65536; n++) begin
         batch_data = (n < 65535) ? 64'h1 : {SIZE{1'b1}};
         tick();
      end
      batch_valid = 1'b0;
      chk("t6 preset", 64'(batches_done), 64'd65535);
      for (int i = 0; i < 64; i++) begin
         chk("t6 valid", 64'(idx_valid), 64'd1);
         chk("t6 idx",   64'(idx),       64'(i));
         chk("t6 rem",   64'(remaining), 64'(64 - i));
         chk("t6 last",  64'(idx_last),  (i == 63) ? 64'd1 : 64'd0);
         tick();
      end
      chk("t6 wrap",       64'(batches_done), 64'd0);
      chk("t6 valid end",  64'(idx_valid),    64'd0);
      batch_valid = 1'b1;
      batch_data  = {SIZE{1'b1}};
      tick();
      batch_valid = 1'b0;
      tick();
      chk("t6 midscan idx", 64'(idx), 64'd1);
      rst_n = 1'b0;
      tick();
      chk("t6 rst idx_valid",   64'(idx_valid),    64'd0);
      chk("t6 rst batch_ready", 64'(batch_ready),  64'd1);
      chk("t6 rst idx",         64'(idx),          64'd0);
      chk("t6 rst idx_last",    64'(idx_last),     64'd0);
      chk("t6 rst remaining",   64'(remaining),    64'd0);
      chk("t6 rst batch_req",   64'(batch_req),    64'd0);
      chk("t6 rst empty",       64'(empty_batch),  64'd0);
      chk("t6 rst done",        64'(batches_done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
